// File: rtl/scroll_ctrl_if.sv
// Column-source handshake and column-shifter bus seen by scroll_ctrl.
// master = the sequencer, slave = the source/shifter side.
interface scroll_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             col_req;
  logic [LEN_W-1:0] col_idx;
  logic [7:0]       col_data;
  logic             col_valid;
  logic [7:0]       ex;
  logic             sh_en;
  logic             sh_dir;
  logic [7:0]       sh_d;
  logic             upd;

  modport master (
    output col_req, col_idx, sh_en, sh_dir, sh_d, upd,
    input  col_data, col_valid, ex
  );

  modport slave (
    input  col_req, col_idx, sh_en, sh_dir, sh_d, upd,
    output col_data, col_valid, ex
  );
endinterface

// File: rtl/scroll_ctrl.sv
// Column-scroll sequencer for the 8x8 MAX7219 path: paces column shifts at a
// programmable rate, streaming bytes from a column source or rotating the ejected column.
module scroll_ctrl #(
  parameter int DIV_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             dir_in,
  input  logic [DIV_W-1:0] period,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             loop,
  scroll_ctrl_if.master    bus,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] period_r;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] len_r;
  logic [7:0]       data_r;
  logic             mode_r, dir_r, loop_r, upd_r;
  logic             abort, cnt_zero, last_col, step;

  // An abort (stop or reset) suppresses every pulse in its own cycle.
  assign abort    = stop | rst;
  assign cnt_zero = (cnt == '0);
  assign last_col = (idx == len_r - LEN_W'(1));
  assign step     = (state == WAIT) && cnt_zero && !abort;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = mode ? WAIT : ((msg_len == '0) ? DONE : FETCH);
        FETCH:   if (bus.col_valid) state_nxt = WAIT;
        WAIT:    if (cnt_zero && !mode_r) state_nxt = (last_col && !loop_r) ? DONE : FETCH;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The step counter keeps running during a fetch so source latency overlaps the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      period_r <= '0;
      idx      <= '0;
      len_r    <= '0;
      data_r   <= '0;
      mode_r   <= 1'b0;
      dir_r    <= 1'b0;
      loop_r   <= 1'b0;
      upd_r    <= 1'b0;
    end else begin
      upd_r <= step;
      if (!stop) begin
        case (state)
          IDLE: begin
            if (start) begin
              mode_r   <= mode;
              dir_r    <= dir_in;
              period_r <= period;
              len_r    <= msg_len;
              loop_r   <= loop;
              cnt      <= period;
              idx      <= '0;
            end
          end
          FETCH: begin
            if (!cnt_zero) cnt <= cnt - DIV_W'(1);
            if (bus.col_valid) data_r <= bus.col_data;
          end
          WAIT: begin
            if (!cnt_zero) begin
              cnt <= cnt - DIV_W'(1);
            end else begin
              cnt <= period_r;
              if (!mode_r) begin
                if (!last_col)   idx <= idx + LEN_W'(1);
                else if (loop_r) idx <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.col_req = (state == FETCH) && !abort;
    bus.col_idx = idx;
    bus.sh_en   = step;
    bus.sh_dir  = dir_r;
    bus.sh_d    = mode_r ? bus.ex : data_r;
    bus.upd     = upd_r;
    busy        = (state == FETCH) || (state == WAIT);
    done        = (state == DONE) && !abort;
  end

endmodule

// File: tb/tb_scroll_ctrl.sv
// Self-checking bench for scroll_ctrl: a responding column source and shifter model,
// with shift times predicted from the period/latency timing rules.
module tb_scroll_ctrl;
  localparam int DIV_W = 24;
  localparam int LEN_W = 8;

  logic             clk    = 1'b0;
  logic             rst    = 1'b1;
  logic             start  = 1'b0;
  logic             stop   = 1'b0;
  logic             mode   = 1'b0;
  logic             dirIn  = 1'b0;
  logic             loopEn = 1'b0;
  logic [DIV_W-1:0] period = '0;
  logic [LEN_W-1:0] msgLen = '0;
  logic             busy, done;

  scroll_ctrl_if #(.LEN_W(LEN_W)) bus ();

  scroll_ctrl #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .dir_in(dirIn), .period(period), .msg_len(msgLen), .loop(loopEn),
    .bus(bus), .busy(busy), .done(done)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   sCyc   = 0;
  logic monEn  = 1'b0;

  logic        respValid = 1'b0;
  logic        lateValid = 1'b0;
  logic [7:0]  respData  = '0;
  logic [7:0]  colMem [256];
  int          fLat [64];
  int          fetchNum  = 0;
  int          reqCount  = 0;
  int          reqCycles = 0;
  int          idxErr    = 0;
  logic [LEN_W-1:0] firstIdx = '0;

  logic [63:0] shReg   = '0;
  logic [63:0] patReg  = '0;
  logic        loadPat = 1'b0;

  int          shTimes [$];
  logic [7:0]  shData [$];
  logic        shDirs [$];
  int          doneTimes [$];
  int          idxSeq [$];
  logic        busyAt [int];
  int          updErr     = 0;
  int          overlapErr = 0;
  logic        prevShEn   = 1'b0;

  int          expTimes [$];
  int          expIdx [$];

  assign bus.col_valid = respValid | lateValid;
  assign bus.col_data  = respData;
  assign bus.ex        = bus.sh_dir ? shReg[63:56] : shReg[7:0];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Column shifter: dir=1 pushes new columns in at the bottom and ejects the top byte.
  always @(posedge clk) begin
    if (loadPat) shReg <= patReg;
    else if (bus.sh_en === 1'b1)
      shReg <= bus.sh_dir ? {shReg[55:0], bus.sh_d} : {bus.sh_d, shReg[63:8]};
  end

  // Column source: answers in the fLat[n]-th cycle of the n-th request.
  always @(negedge clk) begin
    #1;
    respValid = 1'b0;
    if (monEn && bus.col_req === 1'b1) begin
      reqCycles++;
      reqCount++;
      if (reqCount == 1) begin
        firstIdx = bus.col_idx;
        idxSeq.push_back(int'(bus.col_idx));
      end else if (bus.col_idx !== firstIdx) begin
        idxErr++;
      end
      if (reqCount >= fLat[fetchNum]) begin
        respValid = 1'b1;
        respData  = colMem[bus.col_idx];
        reqCount  = 0;
        if (fetchNum < 63) fetchNum++;
      end
    end else begin
      reqCount = 0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (monEn) begin
      busyAt[cyc] = busy;
      if (bus.upd !== prevShEn) updErr++;
      if (bus.sh_en === 1'b1) begin
        shTimes.push_back(cyc);
        shData.push_back(bus.sh_d);
        shDirs.push_back(bus.sh_dir);
        if (bus.col_req === 1'b1) overlapErr++;
      end
      if (done === 1'b1) doneTimes.push_back(cyc);
    end
    prevShEn = bus.sh_en;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic d, input int p, input int n, input logic lp);
    @(negedge clk);
    mode   = m;
    dirIn  = d;
    period = DIV_W'(p);
    msgLen = LEN_W'(n);
    loopEn = lp;
    start  = 1'b1;
    sCyc   = cyc;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic clearLog();
    shTimes.delete();
    shData.delete();
    shDirs.delete();
    doneTimes.delete();
    idxSeq.delete();
    updErr     = 0;
    overlapErr = 0;
    idxErr     = 0;
    reqCycles  = 0;
    fetchNum   = 0;
  endtask

  // Reference timing: each fetch starts the cycle after the previous shift, and the
  // shift lands max(period, F) cycles after the fetch starts.
  function automatic void predict(input int s, input int p, input int n, input int count);
    int fetchStart, f, t;
    expTimes.delete();
    expIdx.delete();
    fetchStart = s + 1;
    for (int k = 0; k < count; k++) begin
      f = fLat[k];
      t = fetchStart + ((p > f) ? p : f);
      expTimes.push_back(t);
      expIdx.push_back(k % n);
      fetchStart = t + 1;
    end
  endfunction

  task automatic checkStream(input string tag, input int n, input logic d);
    checkOutput({tag, " shifts"}, 32'(shTimes.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("%s time%0d", tag, k),
                  (k < shTimes.size()) ? 32'(shTimes[k]) : 32'hFFFF_FFFF, 32'(expTimes[k]));
      checkOutput($sformatf("%s data%0d", tag, k),
                  (k < shData.size()) ? {24'd0, shData[k]} : 32'hFFFF_FFFF, {24'd0, colMem[expIdx[k]]});
      checkOutput($sformatf("%s dir%0d", tag, k),
                  (k < shDirs.size()) ? {31'd0, shDirs[k]} : 32'hFFFF_FFFF, {31'd0, d});
      checkOutput($sformatf("%s idx%0d", tag, k),
                  (k < idxSeq.size()) ? 32'(idxSeq[k]) : 32'hFFFF_FFFF, 32'(expIdx[k]));
    end
    checkOutput({tag, " doneCount"}, 32'(doneTimes.size()), 32'd1);
    checkOutput({tag, " doneTime"},
                (doneTimes.size() > 0) ? 32'(doneTimes[0]) : 32'hFFFF_FFFF, 32'(expTimes[n-1] + 1));
    checkOutput({tag, " updPulse"}, 32'(updErr), 32'd0);
    checkOutput({tag, " noShiftInFetch"}, 32'(overlapErr), 32'd0);
    checkOutput({tag, " idxStable"}, 32'(idxErr), 32'd0);
  endtask

  task automatic runStream(input string tag, input int p, input int n, input logic d,
                           input int fMin, input int fMax);
    int limit;
    clearLog();
    for (int k = 0; k < 64; k++) fLat[k] = int'($urandom_range(fMax, fMin));
    applyStimulus(1'b0, d, p, n, 1'b0);
    predict(sCyc, p, n, n);
    limit = n * (p + fMax + 2) + 10;
    while (doneTimes.size() == 0 && cyc < sCyc + limit) @(negedge clk);
    repeat (2) @(negedge clk);
    checkStream(tag, n, d);
  endtask

  initial begin
    int s, p;

    for (int k = 0; k < 256; k++) colMem[k] = 8'($urandom);
    for (int k = 0; k < 64; k++) fLat[k] = 1;

    // Power-up reset.
    repeat (2) @(negedge clk);
    #3;
    checkOutput("rst col_req", 32'(bus.col_req), 32'd0);
    checkOutput("rst col_idx", 32'(bus.col_idx), 32'd0);
    checkOutput("rst sh_en",   32'(bus.sh_en),   32'd0);
    checkOutput("rst sh_dir",  32'(bus.sh_dir),  32'd0);
    checkOutput("rst sh_d",    32'(bus.sh_d),    32'd0);
    checkOutput("rst upd",     32'(bus.upd),     32'd0);
    checkOutput("rst busy",    32'(busy),        32'd0);
    checkOutput("rst done",    32'(done),        32'd0);
    @(negedge clk);
    rst   = 1'b0;
    monEn = 1'b1;

    // Directed stream: period 3, four columns, same-cycle source, bytes A0..A3.
    for (int k = 0; k < 4; k++) colMem[k] = 8'hA0 + 8'(k);
    runStream("A", 3, 4, 1'b0, 1, 1);
    s = sCyc;
    checkOutput("A firstShift", (shTimes.size() > 0) ? 32'(shTimes[0]) : 32'hFFFF_FFFF, 32'(s + 4));
    checkOutput("A lastShift",  (shTimes.size() > 3) ? 32'(shTimes[3]) : 32'hFFFF_FFFF, 32'(s + 16));
    checkOutput("A data0", (shData.size() > 0) ? {24'd0, shData[0]} : 32'hFFFF_FFFF, 32'h0000_00A0);
    checkOutput("A busyBeforeDone", busyAt.exists(s + 16) ? 32'(busyAt[s + 16]) : 32'hFFFF_FFFF, 32'd1);
    checkOutput("A busyAtDone",     busyAt.exists(s + 17) ? 32'(busyAt[s + 17]) : 32'hFFFF_FFFF, 32'd0);

    // Period 0 with a three-cycle source gives a four-cycle spacing.
    for (int k = 0; k < 256; k++) colMem[k] = 8'($urandom);
    runStream("B", 0, 4, 1'b1, 3, 3);
    s = sCyc;
    checkOutput("B spacing", (shTimes.size() > 1) ? 32'(shTimes[1] - shTimes[0]) : 32'hFFFF_FFFF, 32'd4);

    // Randomised stream runs.
    for (int r = 0; r < 4; r++) begin
      runStream($sformatf("R%0d", r), int'($urandom_range(5, 0)), int'($urandom_range(6, 1)),
                1'($urandom), 1, 4);
    end

    // Rotate: dir 1, period 1, shifter preloaded; eight shifts restore the pattern.
    patReg  = {$urandom, $urandom};
    loadPat = 1'b1;
    @(negedge clk);
    loadPat = 1'b0;
    clearLog();
    applyStimulus(1'b1, 1'b1, 1, 0, 1'b0);
    s = sCyc;
    while (cyc < s + 17) @(negedge clk);
    checkOutput("rot shifts", 32'(shTimes.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("rot time%0d", k),
                  (k < shTimes.size()) ? 32'(shTimes[k]) : 32'hFFFF_FFFF, 32'(s + 1 + 1 + k * 2));
      checkOutput($sformatf("rot data%0d", k),
                  (k < shData.size()) ? {24'd0, shData[k]} : 32'hFFFF_FFFF, {24'd0, patReg[8*(7-k) +: 8]});
    end
    checkOutput("rot dir", (shDirs.size() > 0) ? {31'd0, shDirs[0]} : 32'hFFFF_FFFF, 32'd1);
    #3;
    checkOutput("rot pattern back", shReg[31:0], patReg[31:0]);
    checkOutput("rot pattern back hi", shReg[63:32], patReg[63:32]);
    checkOutput("rot busy", 32'(busy), 32'd1);
    checkOutput("rot noFetch", 32'(reqCycles), 32'd0);
    @(negedge clk);
    stop = 1'b1;
    #3;
    checkOutput("rot stop sh_en", 32'(bus.sh_en), 32'd0);
    @(negedge clk);
    stop = 1'b0;
    #3;
    checkOutput("rot stop busy", 32'(busy), 32'd0);
    checkOutput("rot stop upd", 32'(bus.upd), 32'd0);
    checkOutput("rot noDone", 32'(doneTimes.size()), 32'd0);
    checkOutput("rot updPulse", 32'(updErr), 32'd0);

    // Loop over three columns, then stop exactly on a would-be shift.
    clearLog();
    for (int k = 0; k < 64; k++) fLat[k] = int'($urandom_range(2, 1));
    p = int'($urandom_range(3, 0));
    applyStimulus(1'b0, 1'b0, p, 3, 1'b1);
    s = sCyc;
    predict(s, p, 3, 8);
    while (cyc < expTimes[7]) @(negedge clk);
    stop = 1'b1;
    #3;
    checkOutput("loop stop sh_en", 32'(bus.sh_en), 32'd0);
    @(negedge clk);
    stop = 1'b0;
    #3;
    checkOutput("loop stop busy", 32'(busy), 32'd0);
    checkOutput("loop stop upd", 32'(bus.upd), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("loop shifts", 32'(shTimes.size()), 32'd7);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("loop idx%0d", k),
                  (k < idxSeq.size()) ? 32'(idxSeq[k]) : 32'hFFFF_FFFF, 32'(k % 3));
      if (k < 7)
        checkOutput($sformatf("loop time%0d", k),
                    (k < shTimes.size()) ? 32'(shTimes[k]) : 32'hFFFF_FFFF, 32'(expTimes[k]));
    end
    checkOutput("loop noDone", 32'(doneTimes.size()), 32'd0);
    checkOutput("loop updPulse", 32'(updErr), 32'd0);

    // Empty message completes immediately.
    clearLog();
    applyStimulus(1'b0, 1'b0, 5, 0, 1'b0);
    s = sCyc;
    while (cyc < s + 4) @(negedge clk);
    checkOutput("len0 doneCount", 32'(doneTimes.size()), 32'd1);
    checkOutput("len0 doneTime", (doneTimes.size() > 0) ? 32'(doneTimes[0]) : 32'hFFFF_FFFF, 32'(s + 1));
    checkOutput("len0 noReq", 32'(reqCycles), 32'd0);
    checkOutput("len0 noShift", 32'(shTimes.size()), 32'd0);
    checkOutput("len0 busy", busyAt.exists(s + 1) ? 32'(busyAt[s + 1]) : 32'hFFFF_FFFF, 32'd0);

    // A second start while busy must not disturb the running scroll.
    clearLog();
    for (int k = 0; k < 64; k++) fLat[k] = 1;
    applyStimulus(1'b0, 1'b1, 2, 2, 1'b0);
    s = sCyc;
    predict(s, 2, 2, 2);
    while (cyc < s + 3) @(negedge clk);
    mode = 1'b1; dirIn = 1'b0; period = '0; msgLen = 8'd5; loopEn = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = 1'b0; loopEn = 1'b0;
    while (doneTimes.size() == 0 && cyc < s + 30) @(negedge clk);
    repeat (2) @(negedge clk);
    checkStream("busyStart", 2, 1'b1);

    // start and stop together in IDLE: stop wins.
    clearLog();
    @(negedge clk);
    mode = 1'b0; msgLen = 8'd3; period = DIV_W'(1); start = 1'b1; stop = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    while (cyc < s + 6) @(negedge clk);
    checkOutput("startStop noReq", 32'(reqCycles), 32'd0);
    checkOutput("startStop noShift", 32'(shTimes.size()), 32'd0);
    checkOutput("startStop noDone", 32'(doneTimes.size()), 32'd0);
    checkOutput("startStop busy", 32'(busy), 32'd0);

    // Reset during a slow fetch, then a late response that must be ignored.
    clearLog();
    fLat[0] = 8;
    applyStimulus(1'b0, 1'b1, 2, 2, 1'b0);
    s = sCyc;
    while (cyc < s + 2) @(negedge clk);
    rst = 1'b1;
    #3;
    checkOutput("midRst col_req", 32'(bus.col_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    checkOutput("midRst col_idx", 32'(bus.col_idx), 32'd0);
    checkOutput("midRst sh_en",   32'(bus.sh_en),   32'd0);
    checkOutput("midRst sh_dir",  32'(bus.sh_dir),  32'd0);
    checkOutput("midRst sh_d",    32'(bus.sh_d),    32'd0);
    checkOutput("midRst upd",     32'(bus.upd),     32'd0);
    checkOutput("midRst busy",    32'(busy),        32'd0);
    checkOutput("midRst done",    32'(done),        32'd0);
    @(negedge clk);
    respData  = 8'h5A;
    lateValid = 1'b1;
    @(negedge clk);
    lateValid = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    checkOutput("late busy", 32'(busy), 32'd0);
    checkOutput("late sh_d", 32'(bus.sh_d), 32'd0);
    checkOutput("late noShift", 32'(shTimes.size()), 32'd0);
    checkOutput("late noDone", 32'(doneTimes.size()), 32'd0);
    runStream("afterRst", 2, 2, 1'b1, 1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scroll_ctrl.md
# scroll_ctrl

Column-scroll sequencer for the 8x8 MAX7219 matrix path. It drives the column shifter's enable, direction and input-column byte at a programmable step rate. Column bytes come either from an external glyph/column source through a request/valid handshake (stream mode), or from the shifter's own ejected column fed back in (rotate mode). It sits between the text/font fetch logic and the column shifter, and pulses `upd` after every shift so the MAX7219 refresh engine can push the new frame.

## Interface
- DIV_W, 24, width of step-period counter
- LEN_W, 8, width of message length / column index
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a scroll when idle
- stop  in  1  one-cycle pulse; aborts any scroll
- mode  in  1  0 = stream from column source, 1 = rotate (feed `ex` back); latched at start
- dir_in  in  1  shift direction passed to shifter; latched at start
- period  in  DIV_W  step period minus one, in clk cycles; latched at start
- msg_len  in  LEN_W  columns to stream (stream mode); latched at start
- loop  in  1  1 = wrap to column 0 after last column instead of finishing; latched at start
- col_req  out  1  column fetch request
- col_idx  out  LEN_W  index of requested column
- col_data  in  8  column byte, sampled when col_valid=1
- col_valid  in  1  column source response
- ex  in  8  column ejected by shifter
- sh_en  out  1  shifter enable (one cycle per step)
- sh_dir  out  1  shifter direction
- sh_d  out  8  column byte into shifter
- upd  out  1  one-cycle pulse, cycle after each sh_en
- busy  out  1  high in FETCH/WAIT
- done  out  1  one-cycle pulse at normal completion

## Operation
- States: IDLE, FETCH, WAIT, DONE. Reset → IDLE; all outputs 0, col_idx 0, internal counter/index 0.
- IDLE: on start (stop low) latch mode/dir_in/period/msg_len/loop, cnt←period, idx←0.
  - stream, msg_len≠0 → FETCH; stream, msg_len=0 → DONE; rotate → WAIT.
- FETCH: col_req=1, col_idx=idx. cnt decrements if nonzero. On col_valid: capture col_data into data reg → WAIT. col_req is held until col_valid; no timeout.
- WAIT: if cnt≠0, decrement. If cnt=0: sh_en=1 this cycle, cnt←period, then:
  - rotate: stay WAIT, runs until stop.
  - stream, idx<msg_len-1: idx←idx+1 → FETCH.
  - stream, idx=msg_len-1: if loop, idx←0 → FETCH; else → DONE.
- DONE: done=1 for one cycle → IDLE.
- sh_d = data reg in stream mode; sh_d = ex (combinational) in rotate mode. sh_dir = latched dir, constant for the whole scroll.
- sh_en is a decode of state=WAIT and cnt=0. upd is a registered copy of sh_en.
- busy = (state is FETCH or WAIT); low in IDLE and DONE.
- stop has priority over everything except rst. In any state it forces IDLE next cycle. No sh_en is asserted in the stop cycle, col_req drops, no done pulse, and the shifter contents are untouched.
- start while not IDLE is ignored. start and stop in the same cycle in IDLE: stop wins, stays IDLE.
- rst mid-scroll: same as stop, plus all registers cleared. An outstanding col_valid after abort is ignored.
- idx arithmetic is unsigned LEN_W and wraps only via the loop rule. msg_len=2^LEN_W-1 is the maximum.

## Timing
- start at cycle s → FETCH (stream) or WAIT (rotate) at s+1 with cnt=period.
- Rotate: first sh_en at s+1+period; subsequent sh_en every period+1 cycles. period=0 gives a shift every cycle.
- Stream: shift-to-shift spacing = max(period+1, F+1), where F is the number of cycles col_req is high including the col_valid cycle. Minimum spacing is 2.
- First stream sh_en at s+1+max(period, F).
- upd is high exactly one cycle after each sh_en. done is high one cycle after the last sh_en (non-loop) or at s+1 when msg_len=0.
- col_idx is stable while col_req=1.

## Test plan
- Stream, period=3, msg_len=4, loop=0, col_valid same cycle as col_req, col_data=idx+0xA0 → sh_en at s+4, s+8, s+12, s+16; sh_d=A0,A1,A2,A3; done at s+17; upd one cycle after each sh_en; busy low from s+17.
- Stream, period=0, source latency 3 cycles → spacing 4 cycles; col_idx held while col_req=1; no sh_en while FETCH.
- Rotate, dir_in=1, period=1, ex driven by a shifter model preloaded with a pattern → sh_d equals ex at each sh_en, sh_en every 2 cycles; pattern returns to original after 8 shifts; busy stays high until stop.
- Loop, msg_len=3 → col_idx sequence 0,1,2,0,1,2…, no done; stop mid-WAIT with cnt=0 → no sh_en that cycle, IDLE next cycle, no done.
- msg_len=0 start → done at s+1, no col_req, no sh_en. start during busy is ignored. start+stop together in IDLE → no activity.
- rst asserted during FETCH → next cycle all outputs 0; a late col_valid is ignored; a new start behaves as from power-up.
